// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state enum, widths, reset PC default and the FIFO entry bundle.
package inst_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer with a registered head entry.
// Ports: push/din, pop, flush, full, empty, dout (oldest entry, zero when empty).
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_n [DEPTH];
  ptr_t         rd_q;
  ptr_t         rd_n;
  ptr_t         wr_q;
  ptr_t         wr_n;
  cnt_t         cnt_q;
  cnt_t         cnt_n;
  fetch_entry_t head_n;
  fetch_entry_t dout_q;
  logic         do_push;
  logic         do_pop;

  function automatic ptr_t bump(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full  = (cnt_q == cnt_t'(DEPTH));
  assign empty = (cnt_q == '0);

  // A full buffer still accepts a push when the head leaves
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_n = mem_q;
    rd_n  = rd_q;
    wr_n  = wr_q;
    cnt_n = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
    if (do_pop) begin
      rd_n = bump(rd_q);
    end
    if (do_push) begin
      mem_n[wr_q] = din;
      wr_n        = bump(wr_q);
    end
    if (flush) begin
      rd_n  = '0;
      wr_n  = '0;
      cnt_n = '0;
    end
  end

  // Head is computed from next state so dout is a plain register
  always_comb begin
    head_n = '0;
    if (cnt_n != '0) begin
      head_n = mem_n[rd_n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= rd_n;
      wr_q   <= wr_n;
      cnt_q  <= cnt_n;
      dout_q <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_n;
  end

  assign dout = dout_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory request, redirect/drain FSM, fetch FIFO.
// Ports: mem_req_*/mem_rsp_* to imem, redirect_* from backend, inst_* to decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam logic [XLEN-1:0] BOOT_PC = word_align(RESET_PC);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] redir_pc;
  logic            req_fire;
  logic            rsp_take;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redir_pc = word_align(redirect_pc);

  assign mem_req_valid = !reset && (state == S_REQ) && !fifo_full;
  assign mem_req_addr  = reset ? BOOT_PC : pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response racing a redirect belongs to the old path
  assign rsp_take = (state == S_WAIT) && mem_rsp_valid && !redirect_valid;

  assign inst_valid = !reset && !fifo_empty;
  assign pop        = inst_valid && inst_ready;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  assign push_entry = '{inst: mem_rsp_data, pc: req_pc};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_REQ;
      pc     <= BOOT_PC;
      req_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redir_pc;
      unique case (state)
        S_REQ: begin
          // Request accepted this cycle is now stale
          state <= req_fire ? S_DRAIN : S_REQ;
        end
        S_WAIT, S_DRAIN: begin
          // Outstanding response either lands now or must be drained
          state <= mem_rsp_valid ? S_REQ : S_DRAIN;
        end
        default: state <= S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (req_fire) begin
            state  <= S_WAIT;
            pc     <= pc + 32'd4;
            req_pc <= pc;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (mem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (rsp_take),
    .din  (push_entry),
    .pop  (pop),
    .flush(redirect_valid),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (head)
  );

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the number of fetched-instruction buffer entries.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 mem_req_valid  output  1  SHALL indicate a fetch request to instruction memory.
REQ-006 mem_req_ready  input  1  SHALL indicate memory accepts the request this cycle.
REQ-007 mem_req_addr  output  32  SHALL be the word-aligned fetch address.
REQ-008 mem_rsp_valid  input  1  SHALL indicate read data is valid this cycle; it is never back-pressured.
REQ-009 mem_rsp_data  input  32  SHALL be the instruction word for the oldest outstanding request.
REQ-010 redirect_valid  input  1  SHALL request a fetch restart from redirect_pc.
REQ-011 redirect_pc  input  32  SHALL be the new fetch address; bits [1:0] are ignored and treated as zero.
REQ-012 inst_valid  output  1  SHALL indicate inst and inst_pc are valid for decode.
REQ-013 inst_ready  input  1  SHALL indicate decode consumes the instruction this cycle.
REQ-014 inst  output  32  SHALL be the instruction word presented to decode.
REQ-015 inst_pc  output  32  SHALL be the address inst was fetched from.

Function
REQ-016 At most one memory request SHALL be outstanding, from the mem_req handshake until its mem_rsp_valid.
REQ-017 The FSM SHALL have states REQ, WAIT and DRAIN.
REQ-018 In REQ, mem_req_valid SHALL be 1 only when the FIFO has a free entry; on a mem_req handshake the FSM SHALL go to WAIT and PC SHALL advance by 4, wrapping from 32'hFFFF_FFFC to 0.
REQ-019 In WAIT, mem_rsp_valid SHALL push {mem_rsp_data, request address} into the FIFO and return the FSM to REQ.
REQ-020 mem_req_valid and mem_req_addr SHALL stay stable until the handshake, unless a redirect occurs.
REQ-021 A response SHALL appear on inst_valid no earlier than the cycle after mem_rsp_valid, because the FIFO output is registered.
REQ-022 Instructions SHALL be delivered in fetch order; an entry SHALL pop only when inst_valid and inst_ready are both 1.
REQ-023 On redirect_valid, the FIFO SHALL flush and PC SHALL load {redirect_pc[31:2], 2'b00} for the next request.
REQ-024 A redirect with a request outstanding, or coinciding with a mem_req handshake, SHALL move the FSM to DRAIN.
REQ-025 DRAIN SHALL discard the next mem_rsp_valid and then go to REQ.
REQ-026 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-027 A redirect in the same cycle as an inst handshake SHALL complete that handshake, then flush.
REQ-028 A redirect in the same cycle as a FIFO push SHALL leave the FIFO empty.
REQ-029 With a full FIFO and inst_ready=1, push and pop in the same cycle SHALL both succeed.

Reset
REQ-030 While reset=1, outputs SHALL be mem_req_valid=0, inst_valid=0, mem_req_addr=RESET_PC, inst=0 and inst_pc=0.
REQ-031 While reset=1, PC SHALL be RESET_PC, the FSM SHALL be in REQ and the FIFO SHALL be empty.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding response; memory is reset by the same signal.
REQ-033 mem_req_valid SHALL first assert in the cycle after reset deasserts.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the XLEN=32 constant, the instruction-width constant and the RESET_PC default.
REQ-035 The FIFO SHALL be a separate sub-module, fetch_fifo, with push, pop, flush, full, empty and a registered output.

Verification
REQ-036 Reset release, mem_req_ready=1, memory responds one cycle later with 32'h0000_0013, inst_ready=1 -> mem_req_addr sequence 0,4,8; inst=32'h13, inst_pc=0 with inst_valid=1 two cycles after the first handshake.
REQ-037 inst_ready=0 held for 10 cycles -> exactly FIFO_DEPTH=2 entries fill, mem_req_valid=0 thereafter, no instruction lost when inst_ready returns to 1.
REQ-038 Redirect to 32'h0000_0103 while in WAIT -> the late response is dropped, the next mem_req_addr=32'h0000_0100, and no stale inst_valid occurs.
REQ-039 Redirect in the same cycle as mem_rsp_valid and an inst handshake -> the handshaked instruction is counted, the response is discarded and the FIFO is empty next cycle.
REQ-040 PC=32'hFFFF_FFFC handshake -> the next mem_req_addr=32'h0000_0000.
REQ-041 Reset asserted while in WAIT -> the next cycle shows mem_req_valid=0, inst_valid=0 and mem_req_addr=RESET_PC.
